// File: rtl/key_schedule.sv
// -----------------------------------------------------------------------------
// key_schedule
//   Kuznyechik (GOST R 34.12-2015) round-key expansion. A 256-bit master key is
//   expanded into ten 128-bit round keys K1..K10. The expansion uses 32 Feistel
//   iterations F[C_i], one per clock. The keys live in a register file with a
//   combinational read port indexed by encoder stage 0..9.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-low reset
//   start_i      request expansion of key_i (sampled only in IDLE)
//   key_i        master key, [255:128]=K1, [127:0]=K2
//   busy_o       registered, high in RUN and DONE
//   done_o       one-cycle pulse once all ten keys are written
//   keys_valid_o stored key set is complete and current
//   key_num_i    round-key index 0..9 (0 = K1)
//   key_o        keys[key_num_i], zero for indices 10..15
//
// Configuration
//   KEY_SCHED_CONST_ROM_EN  when defined, C_1..C_32 come from a 32-entry
//                           constant table indexed by iter-1. Otherwise C_iter
//                           is computed as L(iter) through the shared L-transform.
//                           Both builds produce identical cycle behaviour.
//
// Byte order is big-endian throughout: byte 15 is bits [127:120].
// -----------------------------------------------------------------------------
module key_schedule (
  input  logic         clk,
  input  logic         reset,
  input  logic         start_i,
  input  logic [255:0] key_i,
  output logic         busy_o,
  output logic         done_o,
  output logic         keys_valid_o,
  input  logic [3:0]   key_num_i,
  output logic [127:0] key_o
);

  // Fixed by the cipher; not meant to be overridden.
  localparam int NUM_KEYS = 10;
  localparam int NUM_ITER = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_e;

  // pi substitution table. PI[0] is the leftmost byte (0xFC).
  localparam logic [0:255][7:0] PI = {
    128'hFCEEDD11CF6E3116FBC4FADA23C5044D,
    128'hE977F0DB932E99BA1736F1BB14CD5FC1,
    128'hF918655AE25CEF21811C3C428B018E4F,
    128'h058402AEE36A8FA0060BED987FD4D31F,
    128'hEB342C51EAC848ABF22A68A2FD3ACECC,
    128'hB5700E56080C7612BF7213479CB75D87,
    128'h15A19629107B9AC7F391786F9D9EB2B1,
    128'h3275193DFF358A7E6D54C680C3BD0D57,
    128'hDFF524A93EA843C9D779D6F67C22B903,
    128'hE00FECDE7A94B0BCDCE828504E330A4A,
    128'hA79760731E0062441AB83882649F2641,
    128'hAD454692275E552F8CA3A57D69D5953B,
    128'h0758B34086AC1DF730376BE488D9E789,
    128'hE11B83494C3FF8FE8D53AA90CAD88561,
    128'h207167A42D2B095BCB9B25D0BEE56C52,
    128'h59A674D2E6F4B4C0D166AFC2394B63B6
  };

  // Multiply in GF(2^8) modulo x^8 + x^7 + x^6 + x + 1 (low byte 0xC3).
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'hC3 : 8'h00);
    end
    return p;
  endfunction

  // Coefficient of the linear functional l() for byte k (k=15 is the MSB).
  function automatic logic [7:0] l_coef(input int k);
    logic [7:0] c;
    case (k)
      0, 7, 9: c = 8'h01;
      1, 15:   c = 8'h94;
      2, 14:   c = 8'h20;
      3, 13:   c = 8'h85;
      4, 12:   c = 8'h10;
      5, 11:   c = 8'hC2;
      6, 10:   c = 8'hC0;
      8:       c = 8'hFB;
      default: c = 8'h00;
    endcase
    return c;
  endfunction

  // L = R^16. Each R step puts l(state) on top and shifts the other bytes down.
  function automatic logic [127:0] l_xform(input logic [127:0] x);
    logic [127:0] s;
    logic [7:0]   acc;
    s = x;
    for (int r = 0; r < 16; r++) begin
      acc = '0;
      for (int k = 0; k < 16; k++) acc = acc ^ gf_mul(s[8*k +: 8], l_coef(k));
      s = {acc, s[127:8]};
    end
    return s;
  endfunction

  function automatic logic [127:0] s_xform(input logic [127:0] x);
    logic [127:0] y;
    for (int k = 0; k < 16; k++) y[8*k +: 8] = PI[x[8*k +: 8]];
    return y;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e       state_q, state_d;
  logic [5:0]   iter_q, iter_d;
  logic [127:0] a1_q, a1_d;
  logic [127:0] a0_q, a0_d;
  logic [127:0] keys_q [NUM_KEYS];
  logic [127:0] keys_d [NUM_KEYS];
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         valid_q, valid_d;

  // ---------------------------------------------------------------------------
  // Iteration constant C_iter
  // ---------------------------------------------------------------------------
  logic [127:0] c_iter;

`ifdef KEY_SCHED_CONST_ROM_EN
  logic [127:0] c_rom [NUM_ITER];

  for (genvar g = 0; g < NUM_ITER; g++) begin : g_c_rom
    localparam logic [127:0] C_VAL = l_xform(128'(g + 1));
    assign c_rom[g] = C_VAL;
  end

  // iter_q is 1..32 while RUN is active, so iter-1 fits the 5-bit index.
  assign c_iter = c_rom[5'(iter_q - 6'd1)];
`else
  assign c_iter = l_xform({122'd0, iter_q});
`endif

  // One Feistel round: the new a1 is LSX[C](a1) ^ a0.
  logic [127:0] f_out;
  assign f_out = l_xform(s_xform(a1_q ^ c_iter)) ^ a0_q;

  // After iteration 8j the pair lands in slots 2j and 2j+1. iter_q[5:3] is j.
  logic [3:0] wr_idx;
  assign wr_idx = {iter_q[5:3], 1'b0};

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every variable gets a default first so no path leaves one unassigned
  // (which would infer a latch). Blocking '=' is correct inside always_comb.
  always_comb begin
    state_d = state_q;
    iter_d  = iter_q;
    a1_d    = a1_q;
    a0_d    = a0_q;
    keys_d  = keys_q;
    valid_d = valid_q;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          a1_d      = key_i[255:128];
          a0_d      = key_i[127:0];
          keys_d[0] = key_i[255:128];
          keys_d[1] = key_i[127:0];
          iter_d    = 6'd1;
          valid_d   = 1'b0;
          state_d   = ST_RUN;
        end
      end

      ST_RUN: begin
        a1_d   = f_out;
        a0_d   = a1_q;
        iter_d = iter_q + 6'd1;
        if (iter_q[2:0] == 3'd0) begin
          keys_d[wr_idx]        = f_out;
          keys_d[wr_idx | 4'd1] = a1_q;
        end
        if (iter_q == 6'(NUM_ITER)) begin
          // The key set becomes valid in the same cycle that done_o pulses.
          valid_d = 1'b1;
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        iter_d  = 6'd0;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase

    // The outputs are registered copies of the state being entered.
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking '<=' so that all flops update
  // together from pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      iter_q  <= '0;
      a1_q    <= '0;
      a0_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      // NOTE: this key file is deliberately reset. A reset mid-expansion must
      // leave no partial keys readable, so these are flops and not an
      // unreset RAM.
      for (int i = 0; i < NUM_KEYS; i++) keys_q[i] <= '0;
    end else begin
      state_q <= state_d;
      iter_q  <= iter_d;
      a1_q    <= a1_d;
      a0_q    <= a0_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      valid_q <= valid_d;
      keys_q  <= keys_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign keys_valid_o = valid_q;
  assign key_o        = (key_num_i < 4'(NUM_KEYS)) ? keys_q[key_num_i] : '0;

endmodule

// File: tb/tb_key_schedule.sv
// -----------------------------------------------------------------------------
// tb_key_schedule
//   Self-checking bench for key_schedule. Expected round keys come from a
//   table of {key index, expected key} records. A scoreboard queue holds the
//   table set expected for each accepted start. Entries are popped when done_o
//   pulses, and that set is compared against the read port.
// -----------------------------------------------------------------------------
module tb_key_schedule;

  logic         clk = 1'b0;
  logic         reset;
  logic         start_i;
  logic [255:0] key_i;
  logic         busy_o;
  logic         done_o;
  logic         keys_valid_o;
  logic [3:0]   key_num_i;
  logic [127:0] key_o;

  always #5 clk = ~clk;

  key_schedule dut (
    .clk          (clk),
    .reset        (reset),
    .start_i      (start_i),
    .key_i        (key_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .keys_valid_o (keys_valid_o),
    .key_num_i    (key_num_i),
    .key_o        (key_o)
  );

  localparam logic [255:0] STD_KEY =
    256'h8899aabbccddeeff0011223344556677_fedcba98765432100123456789abcdef;
  localparam logic [255:0] ZERO_KEY = '0;

  localparam int SET_STD  = 0;
  localparam int SET_ZERO = 1;

  typedef struct {
    int           set;
    logic [3:0]   num;
    logic [127:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   sb[$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add_vec(input int s, input logic [3:0] n, input logic [127:0] e);
    vec_t v;
    v.set = s;
    v.num = n;
    v.exp = e;
    vecs.push_back(v);
  endtask

  // Apply every table record of one set to the read port.
  task automatic compare_set(input int s);
    foreach (vecs[i]) begin
      if (vecs[i].set == s) begin
        @(negedge clk);
        key_num_i = vecs[i].num;
        #1;
        check($sformatf("set%0d_key%0d", s, vecs[i].num), key_o, vecs[i].exp);
      end
    end
  endtask

  // One expansion, starting from IDLE. If inj > 0, a different key is pulsed on
  // start_i during RUN cycle inj, and the DUT must ignore it.
  task automatic expand(input logic [255:0] k, input int set, input int inj);
    int first;
    int dones;
    int got;
    first = 0;
    dones = 0;
    got   = -1;
    @(negedge clk);
    key_i   = k;
    start_i = 1'b1;
    sb.push_back(set);
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 1) begin
        start_i = 1'b0;
        check("busy_after_accept", 128'(busy_o), 128'd1);
        check("valid_clears_on_accept", 128'(keys_valid_o), 128'd0);
      end
      if (done_o) begin
        dones++;
        if (first == 0) begin
          first = c;
          check("valid_with_done", 128'(keys_valid_o), 128'd1);
          if (sb.size() == 0) check("scoreboard_nonempty", 128'd0, 128'd1);
          else got = sb.pop_front();
        end
      end
      if (inj > 0 && c == inj) begin
        key_i   = ~k;
        start_i = 1'b1;
      end else if (inj > 0 && c == inj + 1) begin
        start_i = 1'b0;
      end
    end
    check("done_latency", 128'(first), 128'd33);
    check("done_count", 128'(dones), 128'd1);
    check("busy_idle_after", 128'(busy_o), 128'd0);
    if (got >= 0) compare_set(got);
  endtask

  initial begin
    int dones;
    int got;

    // Expected read-port values.
    add_vec(SET_STD, 4'd0,  128'h8899aabbccddeeff0011223344556677);
    add_vec(SET_STD, 4'd1,  128'hfedcba98765432100123456789abcdef);
    add_vec(SET_STD, 4'd2,  128'hdb31485315694343228d6aef8cc78c44);
    add_vec(SET_STD, 4'd3,  128'h3d4553d8e9cfec6815ebadc40a9ffd04);
    add_vec(SET_STD, 4'd9,  128'h72e9dd7416bcf45b755dbaa88e4a4043);
    for (int n = 10; n < 16; n++) add_vec(SET_STD, 4'(n), '0);
    add_vec(SET_ZERO, 4'd0, '0);
    add_vec(SET_ZERO, 4'd1, '0);
    for (int n = 10; n < 16; n++) add_vec(SET_ZERO, 4'(n), '0);

    // Reset state.
    reset     = 1'b0;
    start_i   = 1'b0;
    key_i     = '0;
    key_num_i = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 128'(busy_o), 128'd0);
    check("rst_done", 128'(done_o), 128'd0);
    check("rst_valid", 128'(keys_valid_o), 128'd0);
    for (int n = 0; n < 16; n++) begin
      @(negedge clk);
      key_num_i = 4'(n);
      #1;
      check($sformatf("rst_key%0d", n), key_o, '0);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("post_rst_busy", 128'(busy_o), 128'd0);
    check("post_rst_valid", 128'(keys_valid_o), 128'd0);

    // Standard vector.
    expand(STD_KEY, SET_STD, 0);

    // A different key pulsed during RUN cycle 10 must be ignored.
    expand(STD_KEY, SET_STD, 10);

    // Reset during RUN cycle 20 aborts the run.
    @(negedge clk);
    key_i   = STD_KEY;
    start_i = 1'b1;
    sb.push_back(SET_STD);
    dones = 0;
    @(negedge clk);
    start_i = 1'b0;
    for (int c = 2; c < 20; c++) begin
      @(negedge clk);
      if (done_o) dones++;
    end
    #2;
    reset = 1'b0;
    #1;
    check("abort_busy_async", 128'(busy_o), 128'd0);
    check("abort_done", 128'(done_o), 128'd0);
    check("abort_valid", 128'(keys_valid_o), 128'd0);
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      key_num_i = 4'(n);
      #1;
      if (done_o) dones++;
      check($sformatf("abort_key%0d", n), key_o, '0);
    end
    check("abort_no_done", 128'(dones), 128'd0);
    sb.delete();
    @(negedge clk);
    reset = 1'b1;
    expand(STD_KEY, SET_STD, 0);

    // Second start with an all-zero key.
    expand(ZERO_KEY, SET_ZERO, 0);

    // Back-to-back: start held high. key_i changes during the first run and
    // must be sampled fresh for the second.
    @(negedge clk);
    key_i   = STD_KEY;
    start_i = 1'b1;
    sb.push_back(SET_STD);
    dones = 0;
    got   = -1;
    for (int c = 1; c <= 80; c++) begin
      @(negedge clk);
      if (c == 10) key_i = ZERO_KEY;
      if (c == 34) begin
        check("b2b_idle_gap", 128'(busy_o), 128'd0);
        check("b2b_valid_held", 128'(keys_valid_o), 128'd1);
        sb.push_back(SET_ZERO);
      end
      if (c == 35) check("b2b_valid_clears", 128'(keys_valid_o), 128'd0);
      if (done_o) begin
        dones++;
        if (dones == 1) check("b2b_first_done", 128'(c), 128'd33);
        if (dones == 2) check("b2b_second_done", 128'(c), 128'd67);
        if (sb.size() == 0) check("b2b_scoreboard_nonempty", 128'd0, 128'd1);
        else got = sb.pop_front();
      end
      if (c == 67) start_i = 1'b0;
    end
    check("b2b_done_count", 128'(dones), 128'd2);
    check("b2b_last_set", 128'(got), 128'(SET_ZERO));
    if (got >= 0) compare_set(got);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Guard against a hung run.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
